// File: rtl/ram_ksa_shuffler_if.sv
// Bus between the RC4 key-scheduling shuffler and the RAM controller:
// start/finish handshake, secret key, and the single-port RAM signals.
interface ram_ksa_shuffler_if #(
  parameter int RAM_WIDTH = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [KEY_BYTES*8-1:0] key;
  logic [RAM_WIDTH-1:0]   ram_out;
  logic                   finished;
  logic                   busy;
  logic                   write_enable;
  logic [RAM_WIDTH-1:0]   address;
  logic [RAM_WIDTH-1:0]   ram_in;

  modport master (
    output start, key, ram_out,
    input  finished, busy, write_enable, address, ram_in
  );

  modport slave (
    input  start, key, ram_out,
    output finished, busy, write_enable, address, ram_in
  );
endinterface

// File: rtl/ram_ksa_shuffler.sv
// RC4 key-scheduling stage: swaps s[i] and s[j] over the whole S-box RAM,
// with j = j + s[i] + key[i mod KEY_BYTES], using a 9-cycle iteration.
module ram_ksa_shuffler #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_SIZE  = 256,
  parameter int KEY_BYTES = 3
) (
  input logic               clk,
  input logic               reset,
  ram_ksa_shuffler_if.slave bus
);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [RAM_WIDTH-1:0] LAST_I = RAM_WIDTH'(RAM_SIZE - 1);
  localparam logic [KIDX_W-1:0]    LAST_K = KIDX_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J, WR_I, WR_J, NEXT, DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [RAM_WIDTH-1:0]   i, j, si, sj;
  logic [KIDX_W-1:0]      kidx;
  logic [KEY_BYTES*8-1:0] key_q;
  logic [7:0]             key_bytes [KEY_BYTES];
  logic [7:0]             key_byte;

  // Byte 0 is the most significant byte of the key.
  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_key_bytes
    assign key_bytes[b] = key_q[(KEY_BYTES-b)*8-1 -: 8];
  end
  assign key_byte = key_bytes[kidx];

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RD_I;
      RD_I:    state_nxt = WT_I;
      WT_I:    state_nxt = CAP_I;
      CAP_I:   state_nxt = RD_J;
      RD_J:    state_nxt = WT_J;
      WT_J:    state_nxt = CAP_J;
      CAP_J:   state_nxt = WR_I;
      WR_I:    state_nxt = WR_J;
      WR_J:    state_nxt = NEXT;
      NEXT:    state_nxt = (i == LAST_I) ? DONE : RD_I;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic                 busy_c, finished_c, we_c;
  logic [RAM_WIDTH-1:0] addr_c, wdata_c;

  always_comb begin
    busy_c     = 1'b0;
    finished_c = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    unique case (state)
      RD_I, WT_I, CAP_I: begin
        busy_c = 1'b1;
        addr_c = i;
      end
      RD_J, WT_J, CAP_J: begin
        busy_c = 1'b1;
        addr_c = j;
      end
      WR_I: begin
        busy_c  = 1'b1;
        we_c    = 1'b1;
        addr_c  = i;
        wdata_c = sj;
      end
      WR_J: begin
        busy_c  = 1'b1;
        we_c    = 1'b1;
        addr_c  = j;
        wdata_c = si;
      end
      NEXT:    busy_c = 1'b1;
      DONE:    finished_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy         = busy_c;
  assign bus.finished     = finished_c;
  assign bus.write_enable = we_c;
  assign bus.address      = addr_c;
  assign bus.ram_in       = wdata_c;

  // j is updated at CAP_I so the j read group already addresses the new j.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            key_q <= bus.key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
          end
        end
        CAP_I: begin
          si <= bus.ram_out;
          j  <= j + bus.ram_out + RAM_WIDTH'(key_byte);
        end
        CAP_J: sj <= bus.ram_out;
        NEXT: begin
          if (i != LAST_I) begin
            i    <= i + 1'b1;
            kidx <= (kidx == LAST_K) ? '0 : kidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ram_ksa_shuffler.md
Name: ram_ksa_shuffler

Overview:
- Second RC4 stage: runs the key-scheduling shuffle over the S-box RAM after ram_initializer has written s[i]=i.
- For i = 0..RAM_SIZE-1 it computes j = j + s[i] + key[i mod KEY_BYTES] and swaps s[i] and s[j].
- Drives the single-port synchronous RAM through ramcontroller as a second device (its own mode).
- Consumes the initialized RAM. Its output is the scrambled S-box used by the downstream keystream/decrypt stage.

Parameters:
- RAM_WIDTH, 8, data and address width; also the modulus of all j arithmetic (mod 2^RAM_WIDTH).
- RAM_SIZE, 256, number of S-box entries; must equal 2^RAM_WIDTH.
- KEY_BYTES, 3, secret key length in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled only in IDLE.
- key  input  KEY_BYTES*8  secret key; key byte 0 = key[KEY_BYTES*8-1 -: 8] (MSB-first); latched on start acceptance.
- ram_out  input  RAM_WIDTH  RAM q output.
- finished  output  1  one-cycle pulse when the shuffle completes.
- busy  output  1  high from start acceptance until finished.
- write_enable  output  1  RAM write enable.
- address  output  RAM_WIDTH  RAM address.
- ram_in  output  RAM_WIDTH  RAM write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; i=0, j=0, kidx=0.
  - si, sj, key_q cleared.
  - All outputs 0.
  - Reset mid-shuffle abandons the run. RAM contents are then partial, and the S-box must be re-initialized before the next start.
- RAM model:
  - The address is held for a 3-cycle READ/WAIT/CAPTURE group, and ram_out is sampled at the edge ending CAPTURE.
  - This tolerates 1-cycle (unregistered q) and 2-cycle (registered q) RAM latency.
- States and transitions:
  - IDLE: outputs 0. If start=1, latch key, clear i/j/kidx, and go to RD_I.
  - RD_I, WT_I, CAP_I: address=i. At the CAP_I edge: si<=ram_out; j<=j+ram_out+key_byte[kidx] (mod 2^RAM_WIDTH, carries discarded).
  - RD_J, WT_J, CAP_J: address=j (the updated value). At the CAP_J edge: sj<=ram_out.
  - WR_I: address=i, ram_in=sj, write_enable=1.
  - WR_J: address=j, ram_in=si, write_enable=1.
  - NEXT:
    - If i==RAM_SIZE-1, go to DONE.
    - Otherwise i<=i+1 and kidx<=(kidx==KEY_BYTES-1)?0:kidx+1 (counter wrap, no divider); go to RD_I.
  - DONE: finished=1 and busy=0 for exactly one cycle, then IDLE.
- Output decode:
  - write_enable is high only in WR_I and WR_J.
  - ram_in=0 and address=0 outside the read/write states.
- Timing:
  - 9 cycles per iteration, 2304 cycles for RAM_SIZE=256.
  - Counting the first cycle after the start-accepting edge as cycle 1, busy=1 in cycles 1..2304 and finished=1 in cycle 2305.
- Boundary conditions:
  - i==j: WR_I and WR_J both write the same address; the final value equals the original s[i] (a correct no-op swap).
  - j wraps freely mod 256; i never wraps (the run stops at RAM_SIZE-1).
  - start high while busy: ignored.
  - start still high on return to IDLE: a new run begins the next cycle. ramcontroller is responsible for pulsing start.
  - key changes during a run: ignored (latched copy used).

Test Plan:
- Reset then idle, with reset=0 asserted mid-cycle -> all outputs 0 immediately (async); no write_enable for 20 cycles with start=0.
- Initialized RAM (s[i]=i), key=24'h000000, start pulse:
  - write sequence begins (0<-0, 0<-0), (1<-1, 1<-1), (2<-3, 3<-2), (3<-5, 5<-2).
  - finished pulses in cycle 2305.
- Initialized RAM, key=24'h000249: final RAM is compared byte-for-byte against the software KSA model; exactly 512 write_enable cycles are counted.
- Latency stress: bench RAM model with registered q (2-cycle) -> identical final RAM to the 1-cycle model for key=24'hFFFFFF.
- Reset asserted at cycle 1000 of a run -> outputs 0 at once. Re-init plus restart completes with the correct S-box; finished pulses 2305 cycles after the new start.
- start held high through DONE -> busy reasserts the cycle after IDLE, and a second full run occurs; a toggling key during the run does not alter the result.
